mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Parametrised next-generation memory stage.
- Registers EX/MEM control and data, then performs loads and stores over a req/ack memory handshake instead of a fixed single-cycle dmem.
- Holds the pipeline (stall) while an access is outstanding, steers bytes and halfwords to the correct lanes, and extends load data.
- Flags misaligned accesses and memory timeouts, and presents registered writeback-side outputs.

Parameters:
- DATA_W, 32, data/bus width; must be 32 (lane logic fixed to 4 bytes).
- ADDR_W, 32, address width.
- RW_W, 5, destination register index width.
- TIMEOUT, 64, max cycles to wait for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- d_valid  in  1  EX result valid this cycle
- flush  in  1  squash the instruction being captured
- d_memwr  in  1  store
- d_memtoreg  in  1  load
- d_regwr  in  1  writes register
- d_loadext  in  1  1 = sign-extend load, 0 = zero-extend
- d_dsize  in  2  00 byte, 01 half, 11 word, 10 reserved
- d_rw  in  RW_W  destination register
- d_execresult  in  ADDR_W  ALU result / address
- d_busb  in  DATA_W  store data
- stall  out  1  upstream must hold its d_* inputs
- mem_req  out  1  access request
- mem_we  out  1  write
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- mem_be  out  4  byte enables; bit3 = bits 31:24
- mem_wdata  out  DATA_W  lane-steered store data
- mem_ack  in  1  access complete; mem_rdata valid on loads
- mem_rdata  in  DATA_W  read word
- q_valid  out  1  writeback outputs valid
- q_regwr  out  1  register write enable
- q_memtoreg  out  1  select q_dmem
- q_rw  out  RW_W  destination register
- q_execresult  out  DATA_W  passthrough ALU result
- q_dmem  out  DATA_W  extended load data
- q_err  out  1  misaligned, reserved size, or timeout

Behaviour:
- Reset: every output, the capture register, the FSM (state IDLE) and the counter are 0. Reset mid-access drops mem_req in the same edge and discards the op; the stored write outcome is undefined to memory.
- Capture register S loads d_* on an edge when stall=0. The captured valid bit is d_valid & ~flush. Flush never affects an op already in S.
- memop = S.valid & (S.memwr | S.memtoreg).
- Endianness: big-endian. Byte offset a = addr[1:0]; offset 0 is bits 31:24.
  - Byte: be = 1000 >> a.
  - Half: a must be 0 or 2; be = 1100 or 0011.
  - Word: a must be 0; be = 1111.
- Store data is replicated to the selected lanes.
- Misaligned or reserved-size memop: no request is issued. Output on the next edge with q_err=1, q_regwr=0. No stall cycle.
- FSM IDLE: an aligned memop in S moves to ACCESS on that edge, and stall=1 combinationally. Non-memops go straight to the outputs: 1-cycle latency.
- FSM ACCESS:
  - mem_req=1, with addr/we/be/wdata stable, until ack. Counter increments each cycle.
  - mem_ack=1: the edge loads the output registers, returns to IDLE and stall drops in that cycle, so S captures the next op on the same edge. Zero-wait ack (ack in the first ACCESS cycle) is legal.
  - Timeout (counter reaches TIMEOUT-1 without ack, TIMEOUT>0): abort, IDLE, q_valid=1, q_err=1, q_regwr=0. A late ack in IDLE is ignored.
- Load result: select the lane by a and dsize, then sign- or zero-extend to DATA_W per loadext. The word is passed unchanged.
- Output registers:
  - Update only on completion edges; otherwise q_valid=0 the next cycle.
  - q_execresult = S.execresult.
  - q_regwr = S.regwr & S.valid & ~err.
  - A store writes q_dmem=0.
- stall = (state==ACCESS & ~mem_ack) | (state==IDLE & aligned memop in S).

Test Plan:
- Reset mid-access: ACCESS with mem_req=1, reset asserted -> next cycle mem_req=0, q_valid=0, stall=0.
- Byte load, sign-extended: addr=0x1001, dsize=00, loadext=1, ack after 3 cycles with rdata=0x1180_2233 -> be=0100, stall held 3 cycles, q_dmem=0xFFFF_FF80, q_valid one cycle.
- Half store: addr=0x2002, dsize=01, busb=0x0000_ABCD, zero-wait ack -> be=0011, wdata low half 0xABCD, mem_we=1, q_regwr=0.
- Misaligned word load: addr=0x3003 -> no mem_req, next cycle q_err=1, q_regwr=0.
- Timeout: TIMEOUT=4 and ack withheld -> mem_req high exactly 4 cycles, then q_err=1. Ack on cycle 6 is ignored.
- Back-to-back ALU op, load, ALU op with flush on the third -> first output at cycle+1, load held until ack, third captured with valid=0 so no q_valid.

Source files
------------

// File: rtl/mem_stage_hs.sv
// Memory stage with a req/ack data-memory handshake: captures EX/MEM state,
// steers big-endian byte/half/word lanes, stalls while an access is open.
module mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  dsize,
  input  logic [31:0] busb,
  output logic [7:0]  wbyte
);
  always_comb begin
    wbyte = busb[8*LANE +: 8];
    case (dsize)
      2'b00:   wbyte = busb[7:0];
      2'b01:   wbyte = (LANE % 2 == 1) ? busb[15:8] : busb[7:0];
      default: wbyte = busb[8*LANE +: 8];
    endcase
  end
endmodule

module mem_stage_hs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RW_W    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic              flush,
  input  logic              d_memwr,
  input  logic              d_memtoreg,
  input  logic              d_regwr,
  input  logic              d_loadext,
  input  logic [1:0]        d_dsize,
  input  logic [RW_W-1:0]   d_rw,
  input  logic [ADDR_W-1:0] d_execresult,
  input  logic [DATA_W-1:0] d_busb,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              q_valid,
  output logic              q_regwr,
  output logic              q_memtoreg,
  output logic [RW_W-1:0]   q_rw,
  output logic [DATA_W-1:0] q_execresult,
  output logic [DATA_W-1:0] q_dmem,
  output logic              q_err
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic              valid;
    logic              memwr;
    logic              memtoreg;
    logic              regwr;
    logic              loadext;
    logic [1:0]        dsize;
    logic [RW_W-1:0]   rw;
    logic [ADDR_W-1:0] exec;
    logic [DATA_W-1:0] busb;
  } cap_t;

  typedef enum logic {IDLE, ACCESS} state_t;

  cap_t             s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       a;
  logic             memop, misal, bad, go, tmo, done, err_now;
  logic [3:0]       be;
  logic [31:0]      ld;
  logic [3:0][7:0]  rd;
  logic [3:0][7:0]  wd;

  assign a     = s.exec[1:0];
  assign memop = s.valid & (s.memwr | s.memtoreg);
  assign bad   = memop & misal;
  assign go    = memop & ~misal;
  assign rd    = mem_rdata;

  always_comb begin
    be    = 4'b0000;
    misal = 1'b1;
    case (s.dsize)
      2'b00: begin be = 4'b1000 >> a;                       misal = 1'b0; end
      2'b01: begin be = a[1] ? 4'b0011 : 4'b1100;           misal = a[0]; end
      2'b11: begin be = 4'b1111;                            misal = |a;   end
      default: begin be = 4'b0000;                          misal = 1'b1; end
    endcase
  end

  // big-endian: offset 0 lives in lane 3 (bits 31:24)
  always_comb begin
    ld = mem_rdata;
    case (s.dsize)
      2'b00: ld = {{24{s.loadext & rd[2'd3 - a][7]}}, rd[2'd3 - a]};
      2'b01: ld = a[1] ? {{16{s.loadext & rd[1][7]}}, rd[1:0]}
                       : {{16{s.loadext & rd[3][7]}}, rd[3:2]};
      default: ld = mem_rdata;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    mem_lane #(.LANE(i)) u_lane (.dsize(s.dsize), .busb(s.busb), .wbyte(wd[i]));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = ACCESS;
      ACCESS:  if (mem_ack || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == ACCESS);
    tmo     = (TIMEOUT > 0) && (state == ACCESS) && !mem_ack &&
              (cnt == CNT_W'(TIMEOUT - 1));
    stall   = ((state == ACCESS) & ~mem_ack) | ((state == IDLE) & go);
    done    = ((state == IDLE) & ~go) | ((state == ACCESS) & (mem_ack | tmo));
    err_now = (state == IDLE) ? bad : tmo;
  end

  assign mem_we    = mem_req & s.memwr;
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_addr  = {s.exec[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wd;

  always_ff @(posedge clk) begin
    if (reset || state == IDLE) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  // An aborted op is dropped from S so IDLE does not re-issue it.
  always_ff @(posedge clk) begin
    if (reset)
      s <= '0;
    else if (!stall)
      s <= '{valid: d_valid & ~flush, memwr: d_memwr, memtoreg: d_memtoreg,
             regwr: d_regwr, loadext: d_loadext, dsize: d_dsize, rw: d_rw,
             exec: d_execresult, busb: d_busb};
    else if (tmo)
      s.valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid      <= 1'b0;
      q_regwr      <= 1'b0;
      q_memtoreg   <= 1'b0;
      q_rw         <= '0;
      q_execresult <= '0;
      q_dmem       <= '0;
      q_err        <= 1'b0;
    end else if (done) begin
      q_valid      <= s.valid;
      q_regwr      <= s.regwr & s.valid & ~err_now;
      q_memtoreg   <= s.memtoreg;
      q_rw         <= s.rw;
      q_execresult <= DATA_W'(s.exec);
      q_dmem       <= (state == ACCESS && mem_ack && s.memtoreg && !s.memwr) ? ld : '0;
      q_err        <= s.valid & err_now;
    end else begin
      q_valid      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed scenarios plus random ops checked against
// a transaction-level model of lane selection, extension and handshake timing.
module tb_mem_stage_hs;
  logic        clk = 0, reset = 1;
  logic        d_valid = 0, flush = 0, d_memwr = 0, d_memtoreg = 0, d_regwr = 0, d_loadext = 0;
  logic [1:0]  d_dsize = 0;
  logic [4:0]  d_rw = 0;
  logic [31:0] d_execresult = 0, d_busb = 0;
  logic        stall, mem_req, mem_we, mem_ack = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_be;
  logic        q_valid, q_regwr, q_memtoreg, q_err;
  logic [4:0]  q_rw;
  logic [31:0] q_execresult, q_dmem;
  int total = 0, bad = 0;

  mem_stage_hs #(.DATA_W(32), .ADDR_W(32), .RW_W(5), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .flush(flush), .d_memwr(d_memwr),
    .d_memtoreg(d_memtoreg), .d_regwr(d_regwr), .d_loadext(d_loadext), .d_dsize(d_dsize),
    .d_rw(d_rw), .d_execresult(d_execresult), .d_busb(d_busb), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .q_valid(q_valid),
    .q_regwr(q_regwr), .q_memtoreg(q_memtoreg), .q_rw(q_rw), .q_execresult(q_execresult),
    .q_dmem(q_dmem), .q_err(q_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, fl, wr, rdop, rw_en, ext, input logic [1:0] sz,
                       input logic [4:0] rw, input logic [31:0] addr, busb);
    d_valid = v; flush = fl; d_memwr = wr; d_memtoreg = rdop; d_regwr = rw_en;
    d_loadext = ext; d_dsize = sz; d_rw = rw; d_execresult = addr; d_busb = busb;
  endtask

  // One op end to end, with expectations from the big-endian lane rules.
  task automatic run_op(input string nm, input bit wr, rdop, rw_en, ext, input logic [1:0] sz,
                        input logic [4:0] rw, input logic [31:0] addr, busb, rdata,
                        input int dly);
    bit memop, mis;
    int a;
    logic [31:0] ebe, ewd, eld, b;
    drive(1, 0, wr, rdop, rw_en, ext, sz, rw, addr, busb);
    tick();
    d_valid = 0;
    memop = wr | rdop;
    a = int'(addr[1:0]);
    mis = memop && (sz == 2'b10 || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b11 && a != 0));
    ebe = 0; ewd = busb; eld = rdata;
    if (sz == 2'b00) begin
      ebe = 32'(1 << (3 - a));
      ewd = (busb & 32'hFF) * 32'h0101_0101;
      b = (rdata >> (8 * (3 - a))) & 32'hFF;
      eld = (ext && b[7]) ? (b | 32'hFFFF_FF00) : b;
    end else if (sz == 2'b01) begin
      ebe = (a == 0) ? 32'hC : 32'h3;
      ewd = (busb & 32'hFFFF) * 32'h0001_0001;
      b = (rdata >> (8 * (2 - a))) & 32'hFFFF;
      eld = (ext && b[15]) ? (b | 32'hFFFF_0000) : b;
    end else if (sz == 2'b11) ebe = 32'hF;
    if (memop && !mis) begin
      chk({nm, ".stall_idle"}, stall, 1);
      chk({nm, ".req_idle"}, mem_req, 0);
      tick();
      for (int k = 0; k <= dly; k++) begin
        chk({nm, ".req"}, mem_req, 1);
        chk({nm, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({nm, ".be"}, mem_be, ebe);
        chk({nm, ".we"}, mem_we, wr);
        if (wr) chk({nm, ".wdata"}, mem_wdata, ewd);
        if (k == dly) begin
          mem_ack = 1; mem_rdata = rdata; #1;
          chk({nm, ".stall_ack"}, stall, 0);
        end else chk({nm, ".stall_wait"}, stall, 1);
        tick();
      end
      mem_ack = 0; mem_rdata = $urandom;
    end else begin
      chk({nm, ".stall_none"}, stall, 0);
      chk({nm, ".req_none"}, mem_req, 0);
      tick();
    end
    chk({nm, ".q_valid"}, q_valid, 1);
    chk({nm, ".q_err"}, q_err, mis);
    chk({nm, ".q_regwr"}, q_regwr, rw_en & !mis);
    chk({nm, ".q_memtoreg"}, q_memtoreg, rdop);
    chk({nm, ".q_rw"}, q_rw, rw);
    chk({nm, ".q_exec"}, q_execresult, addr);
    chk({nm, ".q_dmem"}, q_dmem, (rdop && !wr && !mis) ? eld : 32'h0);
    chk({nm, ".req_after"}, mem_req, 0);
    tick();
    chk({nm, ".q_valid_drop"}, q_valid, 0);
  endtask

  initial begin
    int reqs;
    // reset state
    tick(); tick();
    chk("rst.q_valid", q_valid, 0);
    chk("rst.stall", stall, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_be", mem_be, 0);
    chk("rst.q_err", q_err, 0);
    chk("rst.q_dmem", q_dmem, 0);
    reset = 0;
    tick();

    run_op("lb_sext", 0, 1, 1, 1, 2'b00, 5'd7, 32'h0000_1001, 32'h0, 32'h1180_2233, 2);
    run_op("sh_zw", 1, 0, 0, 0, 2'b01, 5'd0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0);
    run_op("lw_mis", 0, 1, 1, 0, 2'b11, 5'd9, 32'h0000_3003, 32'h0, 32'h0, 0);
    run_op("lh_zext", 0, 1, 1, 0, 2'b01, 5'd2, 32'h0000_2000, 32'h0, 32'h8765_4321, 1);
    run_op("lw", 0, 1, 1, 1, 2'b11, 5'd3, 32'h0000_4444, 32'h0, 32'hDEAD_BEEF, 0);
    run_op("alu", 0, 0, 1, 0, 2'b10, 5'd31, 32'h1234_5678, 32'h0, 32'h0, 0);

    // timeout: ack withheld, then a late ack while idle
    drive(1, 0, 0, 1, 1, 0, 2'b11, 5'd5, 32'h0000_4000, 32'h0);
    tick();
    d_valid = 0;
    tick();
    reqs = 0;
    for (int c = 1; c <= 8; c++) begin
      mem_ack = (c == 6);
      #1;
      if (mem_req) reqs++;
      if (c == 5) begin
        chk("tmo.q_valid", q_valid, 1);
        chk("tmo.q_err", q_err, 1);
        chk("tmo.q_regwr", q_regwr, 0);
      end
      if (c >= 6) begin
        chk("tmo.late_q_valid", q_valid, 0);
        chk("tmo.late_stall", stall, 0);
      end
      tick();
    end
    mem_ack = 0;
    chk("tmo.req_cycles", reqs, 4);

    // reset mid-access
    drive(1, 0, 0, 1, 1, 0, 2'b11, 5'd6, 32'h0000_6000, 32'h0);
    tick();
    d_valid = 0;
    tick();
    chk("rma.req_before", mem_req, 1);
    reset = 1;
    tick();
    chk("rma.req", mem_req, 0);
    chk("rma.q_valid", q_valid, 0);
    chk("rma.stall", stall, 0);
    reset = 0;
    tick();

    // ALU, load, flushed ALU back to back
    drive(1, 0, 0, 0, 1, 0, 2'b11, 5'd3, 32'h0000_0055, 32'h0);
    tick();
    drive(1, 0, 0, 1, 1, 0, 2'b11, 5'd4, 32'h0000_5000, 32'h0);
    chk("b2b.stall0", stall, 0);
    tick();
    chk("b2b.a_valid", q_valid, 1);
    chk("b2b.a_exec", q_execresult, 32'h55);
    chk("b2b.a_regwr", q_regwr, 1);
    chk("b2b.stall1", stall, 1);
    drive(1, 1, 0, 0, 1, 0, 2'b11, 5'd8, 32'h0000_0077, 32'h0);
    tick();
    chk("b2b.req", mem_req, 1);
    chk("b2b.hold_qv", q_valid, 0);
    tick();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
    chk("b2b.b_valid", q_valid, 1);
    chk("b2b.b_dmem", q_dmem, 32'hCAFE_F00D);
    chk("b2b.b_rw", q_rw, 4);
    tick();
    chk("b2b.c_squashed", q_valid, 0);
    tick();

    // random ops
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_op("rnd", kind == 2, kind == 1, 1'($urandom), 1'($urandom),
             2'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
